// File: rtl/sp_frame_router.sv
// Buffers one service frame, verifies its 16-bit sum and replays W1+data to the addressed channel.
// in_done one cycle after in_req (max one accept per two cycles); input is stalled while replaying.
module sp_frame_router #(
  parameter int         CH_NUM    = 4,
  parameter logic [7:0] BASE_ADDR = 8'hAB,
  parameter int         MAX_SIZE  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_req,
  output logic              in_done,
  output logic [15:0]       out_data,
  output logic [CH_NUM-1:0] out_req,
  output logic              out_last,
  input  logic [CH_NUM-1:0] out_done,
  output logic              frame_ok,
  output logic [7:0]        crc_err_cnt,
  output logic [7:0]        addr_err_cnt
);

  localparam int         DEPTH  = MAX_SIZE + 2;
  localparam int         IW     = $clog2(DEPTH);
  localparam logic [8:0] CH_N   = 9'(CH_NUM);
  localparam logic [8:0] MAX_SZ = 9'(MAX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_TAIL,
    S_DROP,
    S_REPLAY
  } state_t;

  state_t            r_state;
  logic [15:0]       r_buf [0:DEPTH-1];
  logic [15:0]       r_sum;
  logic [7:0]        r_ch;
  logic [7:0]        r_size;
  logic              r_match;
  logic              r_ok;
  logic [8:0]        r_cnt;
  logic [IW-1:0]     r_widx;
  logic [IW-1:0]     r_ridx;
  logic              r_in_done;
  logic              r_frame_ok;
  logic [15:0]       r_out_data;
  logic [CH_NUM-1:0] r_out_req;
  logic              r_out_last;
  logic [7:0]        r_crc_cnt;
  logic [7:0]        r_addr_cnt;

  logic              w_acc;
  logic [7:0]        w_ch;
  logic [7:0]        w_size;
  logic              w_oversize;
  logic              w_sel_done;
  logic [IW-1:0]     w_ridx_nxt;
  logic [CH_NUM-1:0] w_onehot;
  logic              w_wr;
  logic [IW-1:0]     w_widx;

  // The !r_in_done term spaces accepts so in_done never stays high two cycles.
  assign w_acc      = in_req && !r_in_done && (r_state != S_REPLAY);
  assign w_ch       = in_data[15:8] - BASE_ADDR;
  assign w_size     = in_data[15:8];
  assign w_oversize = {1'b0, w_size} > MAX_SZ;
  assign w_sel_done = |(out_done & r_out_req);
  assign w_ridx_nxt = r_ridx + 1'b1;
  assign w_onehot   = CH_NUM'(1) << r_ch;
  assign w_wr       = w_acc && ((r_state == S_HDR) || (r_state == S_DATA));
  assign w_widx     = (r_state == S_HDR) ? '0 : r_widx;

  // W1 sits at index 0 and data words follow, so replay is a straight walk.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[w_widx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sum      <= '0;
      r_ch       <= '0;
      r_size     <= '0;
      r_match    <= 1'b0;
      r_ok       <= 1'b0;
      r_cnt      <= '0;
      r_widx     <= '0;
      r_ridx     <= '0;
      r_in_done  <= 1'b0;
      r_frame_ok <= 1'b0;
      r_out_data <= '0;
      r_out_req  <= '0;
      r_out_last <= 1'b0;
      r_crc_cnt  <= '0;
      r_addr_cnt <= '0;
    end else begin
      r_in_done  <= w_acc;
      r_frame_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_ch    <= w_ch;
            r_match <= {1'b0, w_ch} < CH_N;
            r_sum   <= in_data;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_acc) begin
            r_size <= w_size;
            r_sum  <= r_sum + in_data;
            r_widx <= IW'(1);
            r_cnt  <= {1'b0, w_size};
            if (!r_match || w_oversize) begin
              // Drop consumes data, checksum and trailer regardless of MAX_SIZE.
              r_cnt      <= {1'b0, w_size} + 9'd2;
              r_addr_cnt <= (r_addr_cnt == 8'hFF) ? r_addr_cnt : r_addr_cnt + 8'd1;
              r_state    <= S_DROP;
            end else if (w_size == 8'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_sum  <= r_sum + in_data;
            r_widx <= r_widx + 1'b1;
            r_cnt  <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (w_acc) begin
            r_ok    <= (in_data == r_sum);
            r_state <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (w_acc) begin
            if (r_ok) begin
              r_ridx     <= '0;
              r_out_data <= r_buf[0];
              r_out_req  <= w_onehot;
              r_out_last <= (r_size == 8'd0);
              r_state    <= S_REPLAY;
            end else begin
              r_crc_cnt <= (r_crc_cnt == 8'hFF) ? r_crc_cnt : r_crc_cnt + 8'd1;
              r_state   <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (w_acc) begin
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_REPLAY: begin
          if (w_sel_done) begin
            if (r_out_last) begin
              r_out_req  <= '0;
              r_out_data <= '0;
              r_out_last <= 1'b0;
              r_frame_ok <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_ridx     <= w_ridx_nxt;
              r_out_data <= r_buf[w_ridx_nxt];
              r_out_last <= (w_ridx_nxt == IW'(r_size));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_done      = r_in_done;
  assign out_data     = r_out_data;
  assign out_req      = r_out_req;
  assign out_last     = r_out_last;
  assign frame_ok     = r_frame_ok;
  assign crc_err_cnt  = r_crc_cnt;
  assign addr_err_cnt = r_addr_cnt;

endmodule

// File: tb/tb_sp_frame_router.sv
// Directed bench for sp_frame_router with CH_NUM=2, BASE_ADDR=AB, MAX_SIZE=32.
module tb_sp_frame_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_req;
  logic        in_done;
  logic [15:0] out_data;
  logic [1:0]  out_req;
  logic        out_last;
  logic [1:0]  out_done;
  logic        frame_ok;
  logic [7:0]  crc_err_cnt;
  logic [7:0]  addr_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_cnt  = 0;
  int req_seen = 0;
  int b2b_err = 0;
  int onehot_err = 0;
  int ack_cnt = 0;
  logic prev_done = 1'b0;

  logic [15:0] tx_q[$];
  logic [15:0] exp_q[$];

  sp_frame_router #(.CH_NUM(2), .BASE_ADDR(8'hAB), .MAX_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_req(in_req), .in_done(in_done),
    .out_data(out_data), .out_req(out_req), .out_last(out_last), .out_done(out_done),
    .frame_ok(frame_ok), .crc_err_cnt(crc_err_cnt), .addr_err_cnt(addr_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (out_req != 2'b00) req_seen++;
    if ($countones(out_req) > 1) onehot_err++;
    if (in_done && prev_done) b2b_err++;
    prev_done = in_done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    int t;
    t = 0;
    in_data = w;
    in_req  = 1'b1;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!in_done && t < 50);
    check("in_done_ack", {31'b0, in_done}, 32'd1);
    if (in_done) ack_cnt++;
    in_req = 1'b0;
  endtask

  task automatic send_all();
    foreach (tx_q[i]) send_word(tx_q[i]);
  endtask

  // Acts as channel: waits for each word, optionally stalls, then pulses out_done.
  task automatic recv(input int ch, input int dly, input bit partial);
    int n;
    int t;
    logic [1:0] exp_req;
    n = exp_q.size();
    exp_req = 2'(1 << ch);
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (out_req == 2'b00 && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      check("out_req_sel", {30'b0, out_req}, {30'b0, exp_req});
      for (int d = 0; d < dly; d++) begin
        @(posedge clk); #1;
        check("hold_data", {16'b0, out_data}, {16'b0, exp_q[k]});
        check("bp_in_done", {31'b0, in_done}, 32'd0);
      end
      check("out_data", {16'b0, out_data}, {16'b0, exp_q[k]});
      check("out_last", {31'b0, out_last}, {31'b0, (k == n - 1) && !partial});
      out_done = out_req;
      @(posedge clk); #1;
      out_done = 2'b00;
    end
    if (!partial) begin
      check("frame_ok", {31'b0, frame_ok}, 32'd1);
      check("req_clear", {30'b0, out_req}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; in_data = '0; in_req = 1'b0; out_done = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_done", {31'b0, in_done}, 32'd0);
    check("rst_out_req", {30'b0, out_req}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_frame_ok", {31'b0, frame_ok}, 32'd0);
    check("rst_crc_cnt", {24'b0, crc_err_cnt}, 32'd0);
    check("rst_addr_cnt", {24'b0, addr_err_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Valid frame to channel 0.
    tx_q  = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};
    exp_q = '{16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1};
    send_all();
    recv(0, 0, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("f1_ok_count", ok_cnt, 32'd1);
    check("f1_crc_cnt", {24'b0, crc_err_cnt}, 32'd0);
    check("f1_addr_cnt", {24'b0, addr_err_cnt}, 32'd0);

    // Valid frame to channel 1, ten zero data words.
    tx_q = '{16'hAC00, 16'h0AB2};
    for (int i = 0; i < 10; i++) tx_q.push_back(16'h0000);
    tx_q.push_back(16'hB6B2);
    tx_q.push_back(16'h0000);
    exp_q = '{16'h0AB2};
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0000);
    send_all();
    recv(1, 0, 1'b0);

    // Bad checksum, then a valid frame right after.
    req_seen = 0;
    tx_q = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCE, 16'h0000};
    send_all();
    repeat (10) @(posedge clk); #1;
    check("crc_no_req", req_seen, 32'd0);
    check("crc_cnt_1", {24'b0, crc_err_cnt}, 32'd1);
    tx_q = '{16'hAC00, 16'h0AB2};
    for (int i = 0; i < 10; i++) tx_q.push_back(16'h0000);
    tx_q.push_back(16'hB6B2);
    tx_q.push_back(16'h0000);
    send_all();
    recv(1, 0, 1'b0);

    // Address out of range: all seven words consumed.
    req_seen = 0;
    ack_cnt = 0;
    tx_q = '{16'hAD00, 16'h0300, 16'h1111, 16'h2222, 16'h3333, 16'h1234, 16'h0000};
    send_all();
    repeat (4) @(posedge clk); #1;
    check("addr_acks", ack_cnt, 32'd7);
    check("addr_no_req", req_seen, 32'd0);
    check("addr_cnt_1", {24'b0, addr_err_cnt}, 32'd1);

    // Oversize (0x40 > 32): drop 0x40+2 words after the header.
    ack_cnt = 0;
    tx_q = '{16'hAB00, 16'h4000};
    for (int i = 0; i < 66; i++) tx_q.push_back(16'h0000);
    send_all();
    repeat (4) @(posedge clk); #1;
    check("size_acks", ack_cnt, 32'd68);
    check("size_no_req", req_seen, 32'd0);
    check("addr_cnt_2", {24'b0, addr_err_cnt}, 32'd2);
    check("crc_cnt_kept", {24'b0, crc_err_cnt}, 32'd1);

    // Zero-size frame, channel stalls 5 cycles while the next W0 is already offered.
    tx_q  = '{16'hAB00, 16'h0050, 16'hAB50, 16'h0000};
    exp_q = '{16'h0050};
    send_all();
    in_data = 16'hAC00;
    in_req  = 1'b1;
    recv(0, 5, 1'b0);
    tx_q = '{16'hAC00, 16'h0AB2};
    for (int i = 0; i < 10; i++) tx_q.push_back(16'h0000);
    tx_q.push_back(16'hB6B2);
    tx_q.push_back(16'h0000);
    exp_q = '{16'h0AB2};
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0000);
    send_all();
    recv(1, 0, 1'b0);

    // Reset while the third word of a replay is presented.
    tx_q  = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};
    exp_q = '{16'h06A2, 16'hFFA1};
    send_all();
    recv(0, 0, 1'b1);
    check("w3_data", {16'b0, out_data}, 32'h0001);
    check("w3_req", {30'b0, out_req}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req", {30'b0, out_req}, 32'd0);
    check("mid_rst_data", {16'b0, out_data}, 32'd0);
    check("mid_rst_last", {31'b0, out_last}, 32'd0);
    check("mid_rst_in_done", {31'b0, in_done}, 32'd0);
    check("mid_rst_crc", {24'b0, crc_err_cnt}, 32'd0);
    check("mid_rst_addr", {24'b0, addr_err_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    tx_q = '{16'hAC00, 16'h0AB2};
    for (int i = 0; i < 10; i++) tx_q.push_back(16'h0000);
    tx_q.push_back(16'hB6B2);
    tx_q.push_back(16'h0000);
    exp_q = '{16'h0AB2};
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0000);
    send_all();
    recv(1, 0, 1'b0);

    repeat (2) @(posedge clk); #1;
    check("in_done_b2b", b2b_err, 32'd0);
    check("out_req_onehot", onehot_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_frame_router.md
Name: sp_frame_router

Overview:
- Parametrised service-protocol frame router for N MIL channels sharing one SPI bus.
- Sits between the SPI word receiver (push source) and CH_NUM channel blocks.
- Buffers each incoming frame and checks its 16-bit checksum.
- Replays valid frames to the channel selected by address; frames with bad address, oversize or bad checksum are consumed and dropped, and an error counter is updated.

Parameters:
CH_NUM, 4, number of channels (1..16)
BASE_ADDR, 8'hAB, service address of channel 0; channel i answers BASE_ADDR+i (mod 256)
MAX_SIZE, 32, maximum data words per frame; buffer depth = MAX_SIZE+2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_data  in  16  incoming SPI word
in_req  in  1  source holds high with in_data until in_done
in_done  out  1  one-cycle accept pulse
out_data  out  16  word to channel (shared by all channels)
out_req  out  CH_NUM  one-hot request to target channel
out_last  out  1  high with the final word of a frame
out_done  in  CH_NUM  channel accept pulse
frame_ok  out  1  one-cycle pulse when the last word of a frame is accepted by the channel
crc_err_cnt  out  8  saturating checksum-error count
addr_err_cnt  out  8  saturating address/oversize-drop count

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, counters 0, FSM to IDLE, buffer content discarded. Applies mid-frame and mid-replay; any partially replayed frame is abandoned and out_req drops immediately.
- Frame on input:
  - W0 = {addr[7:0], xx}
  - W1 = {size[7:0], cmd[7:0]}
  - size data words
  - checksum word
  - trailer word (value ignored)
- Checksum = 16-bit modulo-2^16 sum of W0, W1 and all data words. Data words are raw; no escape interpretation.
- Input accept: in any accepting state, in_req=1 produces in_done=1 on the next cycle, and the word is latched that cycle. At most one accept per two cycles; in_done is never asserted two cycles in a row.
- FSM states:
  - IDLE: accept W0; ch = addr-BASE_ADDR (8-bit). Set match = ch<CH_NUM. Load running sum. Go to HDR.
  - HDR: accept W1; store it; add to sum. If !match or size>MAX_SIZE, go to DROP. Otherwise go to DATA, or to CSUM if size==0.
  - DATA: accept size words into the buffer, adding each to sum; then go to CSUM.
  - CSUM: accept the checksum word; record ok = (word==sum); go to TAIL.
  - TAIL: accept the trailer. If ok, go to REPLAY; else crc_err_cnt++ and go to IDLE.
  - DROP: accept and discard the remaining size+2 words (size from W1, 0..255); addr_err_cnt++ on entry; then go to IDLE.
  - REPLAY: present W1, then data[0..size-1], on out_data with out_req[ch]=1. Hold each word until out_done[ch]. out_last is high with the final word (W1 when size==0). After the last accept, pulse frame_ok and go to IDLE. in_done stays 0 throughout REPLAY (back-pressure).
- out_done on non-selected channels is ignored. At most one out_req bit is set at any time.
- Counters saturate at 8'hFF.
- Buffer index wraps never; size>MAX_SIZE is always dropped.

Test Plan:
- CH_NUM=2, BASE=AB. Input AB00,06A2,FFA1,0001,0002,AB45,FFA3,FFA1,5BCF,0000 -> ch0 receives 06A2,FFA1,0001,0002,AB45,FFA3,FFA1 with out_last on the 7th word; frame_ok=1 once; counters 0.
- Input AC00,0AB2,ten 0000 words,B6B2,0000 -> out_req[1] only; ch1 receives 0AB2 then ten 0000 words, last on the 11th word.
- First frame with checksum 5BCE -> no out_req, crc_err_cnt=1. An immediately following valid AC frame is routed normally.
- Input AD00,0300,3 words,checksum,trailer with CH_NUM=2 -> all 7 words acknowledged, no out_req, addr_err_cnt=1. Size 8'h40 with MAX_SIZE=32 -> dropped, addr_err_cnt=2.
- Input AB00,0050,AB50,0000 -> ch0 receives the single word 0050 with out_last=1. Channel delays out_done 5 cycles -> out_data stable, in_done held 0.
- rst=0 during REPLAY word 3 -> outputs 0 next cycle. A new valid frame afterwards is routed correctly.
